// File: rtl/gf4_mulxor_sched_pkg.sv
// Shared constants, field offsets and arbiter encoding for the GF(2^4) multiply/XOR unit issue controller.
// Operand bytes pack share 1 in the upper nibble and share 0 in the lower nibble.
package gf4_mulxor_sched_pkg;

    localparam int GF4_SHARE_W = 4;
    localparam int OP_W        = 2 * GF4_SHARE_W;
    localparam int RND_W       = 16;
    localparam int RES_W       = 16;

    // rnd_data = {ra[3:0], rb[3:0], random[7:0]}
    localparam int RND_RA_LSB   = 12;
    localparam int RND_RB_LSB   = 8;
    localparam int RND_RAND_LSB = 0;
    localparam int RND_RAND_W   = 8;

    // u_res = {tb, zb, yb, xb, ta, za, ya, xa}, each field 2 bits
    localparam int RES_FIELD_W = 2;
    localparam int RES_XA_LSB  = 0;
    localparam int RES_YA_LSB  = 2;
    localparam int RES_ZA_LSB  = 4;
    localparam int RES_TA_LSB  = 6;
    localparam int RES_XB_LSB  = 8;
    localparam int RES_YB_LSB  = 10;
    localparam int RES_ZB_LSB  = 12;
    localparam int RES_TB_LSB  = 14;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_PRI0 = 2'd1,
        ARB_PRI1 = 2'd2
    } arb_state_e;

    function automatic logic [GF4_SHARE_W-1:0] share_of(input logic [OP_W-1:0] op, input logic idx);
        return idx ? op[GF4_SHARE_W +: GF4_SHARE_W] : op[0 +: GF4_SHARE_W];
    endfunction

endpackage

// File: rtl/gf4_mulxor_sched_resp_fifo.sv
// Response buffer: synchronous FIFO with occupancy count; outputs come straight from storage registers
// and read as zero while empty.
module gf4_resp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 21
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    input  logic                         rd_en_i,
    output logic                         rd_valid_o,
    output logic [WIDTH-1:0]             rd_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_wr;
    logic             do_rd;

    assign do_rd = rd_en_i && (count_q != '0);
    assign do_wr = wr_en_i && ((count_q != CNT_W'(DEPTH)) || do_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

    // NOTE: storage is deliberately not reset; only pointers/count are, and the empty-gating below
    // keeps stale entries from ever reaching the outputs.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_valid_o = (count_q != '0);
    assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;

endmodule

// File: rtl/gf4_mulxor_sched.sv
// Issue controller for the shared two-lane masked GF(2^4) unit: arbitrates round datapath vs key schedule,
// pairs each issue with one PRNG word, and buffers the unit result one cycle later with its {id, tag}.
module gf4_mulxor_sched
    import gf4_mulxor_sched_pkg::*;
#(
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [OP_W-1:0]        req0_opa,
    input  logic [OP_W-1:0]        req0_opb,
    input  logic [TAG_W-1:0]       req0_tag,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [OP_W-1:0]        req1_opa,
    input  logic [OP_W-1:0]        req1_opb,
    input  logic [TAG_W-1:0]       req1_tag,
    input  logic                   rnd_valid,
    output logic                   rnd_ready,
    input  logic [RND_W-1:0]       rnd_data,
    output logic [GF4_SHARE_W-1:0] u_opa0,
    output logic [GF4_SHARE_W-1:0] u_opa1,
    output logic [GF4_SHARE_W-1:0] u_opb0,
    output logic [GF4_SHARE_W-1:0] u_opb1,
    output logic [GF4_SHARE_W-1:0] u_ra,
    output logic [GF4_SHARE_W-1:0] u_rb,
    output logic [RND_RAND_W-1:0]  u_random,
    input  logic [RES_W-1:0]       u_res,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [RES_W-1:0]       resp_data,
    output logic                   resp_id,
    output logic [TAG_W-1:0]       resp_tag,
    output logic                   busy
);

    localparam int ENTRY_W = RES_W + 1 + TAG_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int SC_W    = $clog2(STARVE_MAX + 1);

    arb_state_e       state_q, state_d;
    logic [SC_W-1:0]  starve_cnt_q, starve_cnt_d, starve_inc;
    logic             inflight_q;
    logic             inflight_id_q;
    logic [TAG_W-1:0] inflight_tag_q;

    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_rd_data;
    logic               fifo_valid;
    logic               pop;

    logic             any_valid, holder, holder_valid, other_valid;
    logic             grant_id, room, issue, grant_holder, starved;
    logic [OP_W-1:0]  gnt_opa, gnt_opb;
    logic [TAG_W-1:0] gnt_tag;

    assign pop = fifo_valid && resp_ready;

    // The head leaving this cycle counts as a free slot, so a draining buffer sustains one issue per cycle.
    always_comb begin
        any_valid    = req0_valid || req1_valid;
        holder       = (state_q == ARB_PRI1);
        holder_valid = holder ? req1_valid : req0_valid;
        other_valid  = holder ? req0_valid : req1_valid;
        grant_id     = holder_valid ? holder : !holder;
        room         = (FIFO_DEPTH - int'(fifo_count) + int'(pop)) > int'(inflight_q);
        issue        = !rst && any_valid && rnd_valid && room;
        grant_holder = issue && (grant_id == holder);
        starve_inc   = (starve_cnt_q == SC_W'(STARVE_MAX)) ? starve_cnt_q : starve_cnt_q + 1'b1;
        starved      = grant_holder && (starve_inc >= SC_W'(STARVE_MAX)) && other_valid;
    end

    // NOTE: every variable written here gets a default first, so no path can leave it unassigned
    // and infer a latch.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (any_valid) begin
                    state_d      = ARB_PRI0;
                    starve_cnt_d = grant_holder ? SC_W'(1) : '0;
                end
            end
            ARB_PRI0, ARB_PRI1: begin
                if (!any_valid && !inflight_q) begin
                    state_d      = ARB_IDLE;
                    starve_cnt_d = '0;
                end else if ((!holder_valid && other_valid) || starved) begin
                    state_d      = holder ? ARB_PRI0 : ARB_PRI1;
                    starve_cnt_d = '0;
                end else if (grant_holder) begin
                    starve_cnt_d = starve_inc;
                end
            end
            default: begin
                state_d      = ARB_IDLE;
                starve_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        gnt_opa    = grant_id ? req1_opa : req0_opa;
        gnt_opb    = grant_id ? req1_opb : req0_opb;
        gnt_tag    = grant_id ? req1_tag : req0_tag;
        req0_ready = issue && !grant_id;
        req1_ready = issue && grant_id;
        rnd_ready  = issue;
        u_opa0     = '0;
        u_opa1     = '0;
        u_opb0     = '0;
        u_opb1     = '0;
        u_ra       = '0;
        u_rb       = '0;
        u_random   = '0;
        if (issue) begin
            u_opa0   = share_of(gnt_opa, 1'b0);
            u_opa1   = share_of(gnt_opa, 1'b1);
            u_opb0   = share_of(gnt_opb, 1'b0);
            u_opb1   = share_of(gnt_opb, 1'b1);
            u_ra     = rnd_data[RND_RA_LSB +: GF4_SHARE_W];
            u_rb     = rnd_data[RND_RB_LSB +: GF4_SHARE_W];
            u_random = rnd_data[RND_RAND_LSB +: RND_RAND_W];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ARB_IDLE;
            starve_cnt_q   <= '0;
            inflight_q     <= 1'b0;
            inflight_id_q  <= 1'b0;
            inflight_tag_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            inflight_q   <= issue;
            if (issue) begin
                inflight_id_q  <= grant_id;
                inflight_tag_q <= gnt_tag;
            end
        end
    end

    gf4_resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_resp_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (inflight_q),
        .wr_data_i  ({inflight_id_q, inflight_tag_q, u_res}),
        .rd_en_i    (resp_ready),
        .rd_valid_o (fifo_valid),
        .rd_data_o  (fifo_rd_data),
        .count_o    (fifo_count)
    );

    assign resp_valid = fifo_valid;
    assign resp_data  = fifo_rd_data[RES_W-1:0];
    assign resp_tag   = fifo_rd_data[RES_W +: TAG_W];
    assign resp_id    = fifo_rd_data[ENTRY_W-1];
    assign busy       = inflight_q || (fifo_count != '0);

endmodule

// File: tb/tb_gf4_mulxor_sched.sv
// Self-checking bench: the bench plays the GF(2^4) unit (random u_res), scores responses against a queue
// filled from accepted requests, and checks arbitration, backpressure, PRNG starvation and reset.
module tb_gf4_mulxor_sched;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0]       req0_opa, req0_opb, req1_opa, req1_opb;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic             rnd_valid, rnd_ready;
    logic [15:0]      rnd_data;
    logic [3:0]       u_opa0, u_opa1, u_opb0, u_opb1, u_ra, u_rb;
    logic [7:0]       u_random;
    logic [15:0]      u_res;
    logic             resp_valid, resp_ready, resp_id, busy;
    logic [15:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;

    typedef struct packed {
        logic             id;
        logic [TAG_W-1:0] tag;
        logic [15:0]      data;
    } resp_t;

    resp_t            exp_q[$];
    int               grant_q[$];
    int               checks = 0;
    int               errors = 0;
    logic             prev_issue = 1'b0;
    logic             prev_id;
    logic [TAG_W-1:0] prev_tag;
    logic [15:0]      last_cap;

    gf4_mulxor_sched #(.TAG_W(TAG_W), .FIFO_DEPTH(2), .STARVE_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opa(req0_opa), .req0_opb(req0_opb), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opa(req1_opa), .req1_opb(req1_opb), .req1_tag(req1_tag),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
        .u_opa0(u_opa0), .u_opa1(u_opa1), .u_opb0(u_opb0), .u_opb1(u_opb1),
        .u_ra(u_ra), .u_rb(u_rb), .u_random(u_random), .u_res(u_res),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_id(resp_id), .resp_tag(resp_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // One cycle: monitor just after the negedge-driven inputs settle, then advance to the next negedge.
    task automatic tick();
        int               g;
        logic [7:0]       opa, opb;
        logic [TAG_W-1:0] tag;
        resp_t            e, cap;
        #1;
        g = -1;
        if (rst) begin
            exp_q.delete();
            prev_issue = 1'b0;
        end else if (prev_issue) begin
            cap.id   = prev_id;
            cap.tag  = prev_tag;
            cap.data = u_res;
            exp_q.push_back(cap);
            last_cap = u_res;
        end
        prev_issue = 1'b0;
        checks++;
        if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
            errors++;
            $display("FAIL dual_grant: req0_ready=1 req1_ready=1, required at most one");
        end
        checks++;
        if (rnd_ready === 1'b1 && rnd_valid !== 1'b1) begin
            errors++;
            $display("FAIL rnd_consume: rnd_ready=1 while rnd_valid=%b, required 0", rnd_valid);
        end
        if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
            g   = (req1_ready === 1'b1) ? 1 : 0;
            opa = (g == 1) ? req1_opa : req0_opa;
            opb = (g == 1) ? req1_opb : req0_opb;
            tag = (g == 1) ? req1_tag : req0_tag;
            checks++;
            if ({u_opa1, u_opa0, u_opb1, u_opb0, u_ra, u_rb, u_random} !== {opa, opb, rnd_data}) begin
                errors++;
                $display("FAIL unit_operands: got %h required %h",
                         {u_opa1, u_opa0, u_opb1, u_opb0, u_ra, u_rb, u_random}, {opa, opb, rnd_data});
            end
            checks++;
            if (rnd_ready !== 1'b1) begin
                errors++;
                $display("FAIL issue_rnd_ready: got %b required 1", rnd_ready);
            end
            prev_issue = 1'b1;
            prev_id    = (g == 1);
            prev_tag   = tag;
        end else begin
            checks++;
            if ({u_opa1, u_opa0, u_opb1, u_opb0, u_ra, u_rb, u_random, rnd_ready} !== 33'd0) begin
                errors++;
                $display("FAIL unit_idle: got %h required 0",
                         {u_opa1, u_opa0, u_opb1, u_opb0, u_ra, u_rb, u_random, rnd_ready});
            end
        end
        grant_q.push_back(g);
        if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got id=%b tag=%h data=%h, required no response",
                         resp_id, resp_tag, resp_data);
            end else begin
                e = exp_q.pop_front();
                if ({resp_id, resp_tag, resp_data} !== e) begin
                    errors++;
                    $display("FAIL resp: got id=%b tag=%h data=%h required id=%b tag=%h data=%h",
                             resp_id, resp_tag, resp_data, e.id, e.tag, e.data);
                end
            end
        end
        @(negedge clk);
        u_res = 16'($urandom);
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0; rnd_valid = 1'b0;
        req0_opa = '0; req0_opb = '0; req0_tag = '0;
        req1_opa = '0; req1_opb = '0; req1_tag = '0;
        rnd_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        grant_q.delete();
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, got, req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; resp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; rnd_valid = 1'b1;
        req0_opa = 8'hFF; req1_opa = 8'hEE; rnd_data = 16'hFFFF;
        tick();
        tick();
        #1;
        checks++;
        if ({req0_ready, req1_ready, rnd_ready, resp_valid, resp_data, resp_id, resp_tag, busy,
             u_opa0, u_opa1, u_opb0, u_opb1, u_ra, u_rb, u_random} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b%b%b resp_valid=%b data=%h id=%b tag=%h busy=%b, required all 0",
                     req0_ready, req1_ready, rnd_ready, resp_valid, resp_data, resp_id, resp_tag, busy);
        end
        idle_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_opa = 8'h5A; req0_opb = 8'hC3; req0_tag = 4'd3;
        rnd_valid = 1'b1; rnd_data = 16'h9E71;
        #1;
        checks++;
        if ({u_opa0, u_opa1, u_opb0, u_opb1} !== 16'hA53C) begin
            errors++;
            $display("FAIL single_operands: got %h required a53c", {u_opa0, u_opa1, u_opb0, u_opb1});
        end
        check_bit("single_req0_ready", req0_ready, 1'b1);
        tick();
        idle_inputs();
        #1;
        check_bit("single_resp_early", resp_valid, 1'b0);
        check_bit("single_busy", busy, 1'b1);
        tick();
        #1;
        check_bit("single_resp_valid", resp_valid, 1'b1);
        checks++;
        if ({resp_id, resp_tag, resp_data} !== {1'b0, 4'd3, last_cap}) begin
            errors++;
            $display("FAIL single_resp: got id=%b tag=%h data=%h required id=0 tag=3 data=%h",
                     resp_id, resp_tag, resp_data, last_cap);
        end
        tick();
        #1;
        check_bit("single_drained", busy, 1'b0);
    endtask

    task automatic test_contention();
        int run_idle0, run_idle1, max_idle;
        int exp_g;
        do_reset();
        resp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            req0_valid = 1'b1; req1_valid = 1'b1; rnd_valid = 1'b1;
            req0_opa = 8'($urandom); req0_opb = 8'($urandom); req0_tag = TAG_W'(c);
            req1_opa = 8'($urandom); req1_opb = 8'($urandom); req1_tag = TAG_W'(15 - c);
            rnd_data = 16'($urandom);
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 4; c++) tick();
        run_idle0 = 0; run_idle1 = 0; max_idle = 0;
        for (int c = 0; c < 20; c++) begin
            exp_g = (c < 8) ? 0 : ((c < 16) ? 1 : 0);
            checks++;
            if (grant_q[c] != exp_g) begin
                errors++;
                $display("FAIL contention_grant[%0d]: got %0d required %0d", c, grant_q[c], exp_g);
            end
            run_idle0 = (grant_q[c] == 0) ? 0 : run_idle0 + 1;
            run_idle1 = (grant_q[c] == 1) ? 0 : run_idle1 + 1;
            if (run_idle0 > max_idle) max_idle = run_idle0;
            if (run_idle1 > max_idle) max_idle = run_idle1;
        end
        checks++;
        if (max_idle > 8) begin
            errors++;
            $display("FAIL contention_idle: got %0d consecutive idle cycles, required at most 8", max_idle);
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        resp_ready = 1'b0;
        req0_valid = 1'b1; rnd_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            req0_opa = 8'($urandom); req0_tag = TAG_W'(c); rnd_data = 16'($urandom);
            tick();
        end
        n = 0;
        foreach (grant_q[i]) if (grant_q[i] >= 0) n++;
        checks++;
        if (n != 2 || grant_q[0] != 0 || grant_q[1] != 0) begin
            errors++;
            $display("FAIL bp_first_issues: got %0d issues (first %0d,%0d) required 2 in cycles 0,1",
                     n, grant_q[0], grant_q[1]);
        end
        #1;
        check_bit("bp_stalled_ready", req0_ready, 1'b0);
        grant_q.delete();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        n = 0;
        foreach (grant_q[i]) if (grant_q[i] >= 0) n++;
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL bp_one_more: got %0d issues required 1", n);
        end
        idle_inputs();
        resp_ready = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        #1;
        check_bit("bp_drained", busy, 1'b0);
    endtask

    task automatic test_prng_starve();
        logic [3:0] pat;
        int         exp_g;
        do_reset();
        resp_ready = 1'b1;
        req0_valid = 1'b1;
        pat = 4'b1001;
        for (int c = 0; c < 4; c++) begin
            rnd_valid = pat[c]; rnd_data = 16'($urandom);
            req0_opa = 8'($urandom); req0_tag = TAG_W'(c + 4);
            #1;
            if (!pat[c]) check_bit("starve_no_ready", req0_ready, 1'b0);
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 4; c++) tick();
        for (int c = 0; c < 4; c++) begin
            exp_g = pat[c] ? 0 : -1;
            checks++;
            if (grant_q[c] != exp_g) begin
                errors++;
                $display("FAIL starve_grant[%0d]: got %0d required %0d", c, grant_q[c], exp_g);
            end
        end
    endtask

    task automatic test_req1_only();
        do_reset();
        resp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            req1_valid = 1'b1; rnd_valid = 1'b1;
            req1_opa = 8'($urandom); req1_opb = 8'($urandom); req1_tag = TAG_W'(c + 10);
            rnd_data = 16'($urandom);
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 4; c++) tick();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (grant_q[c] != 1) begin
                errors++;
                $display("FAIL req1_only_grant[%0d]: got %0d required 1", c, grant_q[c]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_tag = 4'd9; req0_opa = 8'h3C; rnd_valid = 1'b1; rnd_data = 16'h1234;
        #1;
        check_bit("mid_issue", req0_ready, 1'b1);
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({resp_valid, resp_data, resp_id, resp_tag, busy, req0_ready, req1_ready, rnd_ready,
             u_opa0, u_opa1, u_opb0, u_opb1, u_ra, u_rb, u_random} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got resp_valid=%b data=%h id=%b tag=%h busy=%b, required all 0",
                     resp_valid, resp_data, resp_id, resp_tag, busy);
        end
        for (int c = 0; c < 5; c++) begin
            #1;
            check_bit("mid_no_resp", resp_valid, 1'b0);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        resp_ready = 1'b0;
        u_res = 16'($urandom);
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_prng_starve();
        test_req1_only();
        test_reset_midflight();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_resp: got %0d undelivered responses required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
